// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM burst controller.
//   state_e       : controller FSM states
//   clogb2        : ceiling log2, used to derive address width from depth
//   LEN_WIDTH_DEF : default burst-length field width
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int LEN_WIDTH_DEF = 8;

  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_burst_ctrl_if.sv
// Command / write-beat / read-beat bundle of the RAM burst controller.
//   cmd_*  : burst command handshake (valid/ready)
//   wr_*   : write beat stream (valid/ready)
//   rd_*   : read beat stream (valid only, no backpressure)
//   busy, done : status
// master modport: the traffic source/sink; slave modport: the controller.
interface ram_burst_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;
  logic                  busy;
  logic                  done;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy, done
  );
endinterface

// File: rtl/ram_rd_pipe.sv
// Read return pipeline.
//   issue_vld/issue_last : tag of the address issued this cycle
//   ram_dout             : RAM read data (valid the cycle after issue)
//   rd_valid/rd_last     : tag delayed two cycles
//   rd_data              : ram_dout captured in the cycle after issue
// Reset clears the tags so in-flight beats are dropped, never emitted.
module ram_rd_pipe #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_vld,
  input  logic                  issue_last,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic                  vld_p1_q, vld_p1_d;
  logic                  last_p1_q, last_p1_d;
  logic                  vld_p2_q, vld_p2_d;
  logic                  last_p2_q, last_p2_d;
  logic [DATA_WIDTH-1:0] rd_data_p2_q, rd_data_p2_d;

  always_comb begin
    // stage p1: RAM is reading the issued address
    vld_p1_d     = issue_vld;
    last_p1_d    = issue_vld & issue_last;
    // stage p2: RAM output captured alongside its tag
    vld_p2_d     = vld_p1_q;
    last_p2_d    = last_p1_q;
    rd_data_p2_d = vld_p1_q ? ram_dout : rd_data_p2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q     <= 1'b0;
      last_p1_q    <= 1'b0;
      vld_p2_q     <= 1'b0;
      last_p2_q    <= 1'b0;
      rd_data_p2_q <= '0;
    end else begin
      vld_p1_q     <= vld_p1_d;
      last_p1_q    <= last_p1_d;
      vld_p2_q     <= vld_p2_d;
      last_p2_q    <= last_p2_d;
      rd_data_p2_q <= rd_data_p2_d;
    end
  end

  assign rd_valid = vld_p2_q;
  assign rd_last  = last_p2_q;
  assign rd_data  = rd_data_p2_q;

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst command front-end for a single-port synchronous RAM
// (active-low write enable, registered read address, 1-cycle read latency).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : command / write-beat / read-beat bundle (slave side)
//   ram_we_n   : RAM write enable, low only on an accepted write beat
//   ram_addr   : RAM address, incrementing, wraps modulo DEPTH
//   ram_din    : RAM write data (zero when not writing)
//   ram_dout   : RAM read data
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int DEPTH      = 1024,
  parameter  int LEN_WIDTH  = LEN_WIDTH_DEF,
  localparam int ADDR_WIDTH = clogb2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_burst_ctrl_if.slave       bus,
  output logic                  ram_we_n,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  beats_left_q, beats_left_d;
  logic                  done_q, done_d;

  logic                  cmd_ready_c;
  logic                  wr_ready_c;
  logic                  busy_c;
  logic                  issue_vld;
  logic                  issue_last;
  logic                  rd_valid;
  logic                  rd_last;
  logic [DATA_WIDTH-1:0] rd_data;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic; the address counter wraps naturally since DEPTH is 2^n
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          cur_addr_d   = bus.cmd_addr;
          beats_left_d = bus.cmd_len;
          state_d      = bus.cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (bus.wr_valid) begin
          cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
          if (beats_left_q == '0) state_d = IDLE;
          else beats_left_d = beats_left_q - LEN_WIDTH'(1);
        end
      end
      READ: begin
        cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
        if (beats_left_q == '0) state_d = DRAIN;
        else beats_left_d = beats_left_q - LEN_WIDTH'(1);
      end
      DRAIN: begin
        // wait for the final beat to come out of the return pipe
        if (rd_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // registered, so it lands in the first IDLE cycle after a burst
    done_d = (state_q != IDLE) && (state_d == IDLE);
  end

  // Output logic
  always_comb begin
    cmd_ready_c = 1'b0;
    wr_ready_c  = 1'b0;
    busy_c      = 1'b1;
    ram_we_n    = 1'b1;
    ram_addr    = cur_addr_q;
    ram_din     = '0;
    issue_vld   = 1'b0;
    issue_last  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready_c = 1'b1;
        busy_c      = 1'b0;
      end
      WRITE: begin
        wr_ready_c = 1'b1;
        if (bus.wr_valid) begin
          ram_we_n = 1'b0;
          ram_din  = bus.wr_data;
        end
      end
      READ: begin
        issue_vld  = 1'b1;
        issue_last = (beats_left_q == '0);
      end
      DRAIN: ;
      default: ;
    endcase
  end

  ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_vld  (issue_vld),
    .issue_last (issue_last),
    .ram_dout   (ram_dout),
    .rd_valid   (rd_valid),
    .rd_last    (rd_last),
    .rd_data    (rd_data)
  );

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.wr_ready  = wr_ready_c;
  assign bus.busy      = busy_c;
  assign bus.done      = done_q;
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_last   = rd_last;
  assign bus.rd_data   = rd_data;

endmodule
